dr_store_port: RTL and testbench
================================

# dr_store_port

Write-side companion to the 16-bit data register: accepts a store strobe carrying an address and a DR word, buffers it in a small FIFO, and performs the memory write over a WE/ACK handshake with a bounded wait. It sits between the register/control unit and the memory port and runs in the same clock domain. Memory stalls are absorbed, lost stores are flagged, and writes that never get acknowledged are flagged and discarded.

## Interface
- DATA_W, 16, data word width (matches DR)
- ADDR_W, 12, memory address width
- DEPTH, 2, FIFO entries; power of two, ≥2
- TIMEOUT, 15, maximum cycles M_WE is held waiting for M_ACK; ≥1
- CLK  in  1  clock; all state updates on the rising edge
- CLR_N  in  1  reset, asynchronous, active-low
- ST  in  1  store strobe; push {inAR, inDR} when not full
- inAR  in  ADDR_W  store address
- inDR  in  DATA_W  store data
- ERR_CLR  in  1  synchronous clear of ERR and OVF
- BUSY  out  1  FIFO full
- EMPTY  out  1  FIFO empty and FSM in IDLE (no store pending)
- M_WE  out  1  memory write request
- M_ADDR  out  ADDR_W  write address, stable while M_WE=1
- M_DATA  out  DATA_W  write data, stable while M_WE=1
- M_ACK  in  1  memory accepts the write
- ERR  out  1  sticky: a write timed out
- OVF  out  1  sticky: a store was dropped because the FIFO was full

## Operation
- FIFO: circular buffer with DEPTH entries of {addr, data}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Push when ST=1 and the count is not DEPTH, sampled before the edge. A pop in the same cycle does not free a slot for that push.
- ST=1 while full: the word is dropped, OVF is set, and the FIFO is unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, load M_ADDR/M_DATA from the head, clear the wait counter, and go to WR.
  - WR: M_WE=1. If M_ACK=1, pop the head and go to IDLE. Otherwise, if the wait counter equals TIMEOUT-1, pop the head, set ERR, and go to IDLE. Otherwise, increment the wait counter.
- M_ACK and timeout on the same edge: M_ACK wins, ERR is not set.
- M_ACK outside WR is ignored.
- ERR_CLR=1 clears ERR and OVF. A same-cycle set takes priority over the clear.
- Push and pop in the same cycle: both apply and the count is unchanged.

## Timing
- Reset values (asynchronous): M_WE=0, M_ADDR=0, M_DATA=0, ERR=0, OVF=0, BUSY=0, EMPTY=1, FSM=IDLE, pointers=0, count=0, wait counter=0.
- All outputs are registered or decoded directly from registered state. There is no combinational path from ST or M_ACK to any output.
- Latency: ST sampled at edge k into an empty, idle block → M_WE=1 from edge k+1.
- M_ACK sampled high at edge j → M_WE=0 after edge j. The next write can start at edge j+1, so M_WE rises again after edge j+1.
- Minimum spacing is 2 cycles per write (one IDLE cycle plus one WR cycle).
- M_WE stays high for at most TIMEOUT consecutive cycles.
- BUSY and EMPTY update on the edge after the push or pop that changes them.
- CLR_N asserted mid-write: M_WE drops immediately (asynchronously), and FIFO contents and flags are lost.

## Structure
- Shared package holds:
  - the FSM state enum {IDLE, WR}
  - a store-entry typedef {addr, data}
  - default width constants DATA_W_DEF=16 and ADDR_W_DEF=12, reused by the DR/control blocks
- One sub-module, store_fifo: parameterised DEPTH, entry width, push/pop, full/empty/count, same CLK/CLR_N.
- The FSM, wait counter and flags live in dr_store_port.

## Test plan
- Single store: reset, then ST with inAR=0x123, inDR=0xBEEF for one cycle, M_ACK tied high.
  - Required: M_WE high for exactly 1 cycle, starting the cycle after the ST edge, with M_ADDR=0x123, M_DATA=0xBEEF.
  - Then EMPTY=1 and ERR=0.
- Back-pressure and overflow: M_ACK=0, then ST on 4 consecutive cycles with data 0x0001..0x0004.
  - Required: BUSY=1 after the second push and OVF=1.
  - With M_ACK raised, the writes seen are exactly 0x0001 then 0x0002. The third and fourth words are never written.
- Timeout: one store with M_ACK held 0.
  - Required: M_WE high exactly 15 cycles, then ERR=1 and EMPTY=1.
  - ERR_CLR pulse → ERR=0.
- ACK on the timeout edge: M_ACK=1 only in the 15th WR cycle.
  - Required: normal pop, ERR stays 0.
- Wrap-around and simultaneous push/pop: 10 stores at 0x0A0..0x0A9 with ACK one cycle after M_WE rises, ST timed to coincide with pops.
  - Required: all 10 written in order, no OVF, and a push coinciding with a pop leaves the count unchanged.
- Reset mid-operation: CLR_N low while M_WE=1 and the FIFO is full.
  - Required: M_WE=0 at once, EMPTY=1, BUSY=0, ERR=0, OVF=0.
  - Nothing is written after CLR_N is released.

Source files
------------

// File: rtl/dr_store_port_pkg.sv
// Shared definitions for the DR store port and its companion register/control blocks.
`timescale 1ns/1ps
package dr_store_port_pkg;

  // Default widths shared with the DR and control blocks
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

  // Write-side handshake states
  typedef enum logic {
    IDLE = 1'b0,
    WR   = 1'b1
  } portStateT;

  // One buffered store at default widths; address sits above data
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } storeEntryT;

endpackage

// File: rtl/dr_store_port_store_fifo.sv
// Small circular buffer holding pending {addr, data} stores.
// A pop in the same cycle never frees a slot for a push made while full.
`timescale 1ns/1ps
module store_fifo
  import dr_store_port_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = ADDR_W_DEF + DATA_W_DEF
) (
  input  logic                       CLK,
  input  logic                       CLR_N,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ENTRY_W-1:0]         wrData,
  output logic [ENTRY_W-1:0]         rdData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   wrPtrReg;
  logic [PTR_W-1:0]   rdPtrReg;
  logic [CNT_W-1:0]   countReg;
  logic [ENTRY_W-1:0] slotView [DEPTH];
  logic               doPush;
  logic               doPop;

  assign full   = (countReg == CNT_W'(DEPTH));
  assign empty  = (countReg == '0);
  assign count  = countReg;
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = slotView[rdPtrReg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gSlot
      logic [ENTRY_W-1:0] slotReg;

      // Capture the pushed word when the write pointer selects this slot
      always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
          slotReg <= '0;
        end else if (doPush && (wrPtrReg == PTR_W'(gi))) begin
          slotReg <= wrData;
        end
      end

      assign slotView[gi] = slotReg;
    end
  endgenerate

  // Advance pointers (wrapping modulo DEPTH) and track occupancy
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (doPop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      countReg <= countReg + {{(CNT_W-1){1'b0}}, doPush} - {{(CNT_W-1){1'b0}}, doPop};
    end
  end

endmodule

// File: rtl/dr_store_port.sv
// DR store port: buffers store strobes and issues each as a WE/ACK memory write
// with a bounded wait. Unacknowledged writes are discarded and flagged in ERR.
`timescale 1ns/1ps
module dr_store_port
  import dr_store_port_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              ST,
  input  logic [ADDR_W-1:0] inAR,
  input  logic [DATA_W-1:0] inDR,
  input  logic              ERR_CLR,
  output logic              BUSY,
  output logic              EMPTY,
  output logic              M_WE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_DATA,
  input  logic              M_ACK,
  output logic              ERR,
  output logic              OVF
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);

  portStateT          stateReg;
  logic [WAIT_W-1:0]  waitCntReg;
  logic [ENTRY_W-1:0] headEntry;
  logic [CNT_W-1:0]   fifoCount;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               waitDone;
  logic               ackPop;
  logic               timeoutPop;
  logic               fifoPop;
  logic               dropStore;

  // Last permitted wait cycle: give up on the edge that ends it unless ACK arrives
  assign waitDone   = (waitCntReg == WAIT_W'(TIMEOUT - 1));
  assign ackPop     = (stateReg == WR) && M_ACK;
  assign timeoutPop = (stateReg == WR) && !M_ACK && waitDone;
  assign fifoPop    = (ackPop || timeoutPop) && (fifoCount != '0);
  assign dropStore  = ST && fifoFull;

  assign BUSY  = fifoFull;
  assign EMPTY = fifoEmpty && (stateReg == IDLE);

  store_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) fifo (
    .CLK    (CLK),
    .CLR_N  (CLR_N),
    .push   (ST),
    .pop    (fifoPop),
    .wrData ({inAR, inDR}),
    .rdData (headEntry),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  // Write handshake: load the head in IDLE, hold WE until ACK or the wait expires
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      stateReg   <= IDLE;
      waitCntReg <= '0;
      M_WE       <= 1'b0;
      M_ADDR     <= '0;
      M_DATA     <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (!fifoEmpty) begin
            M_ADDR     <= headEntry[DATA_W +: ADDR_W];
            M_DATA     <= headEntry[DATA_W-1:0];
            waitCntReg <= '0;
            M_WE       <= 1'b1;
            stateReg   <= WR;
          end
        end
        WR: begin
          if (M_ACK || waitDone) begin
            M_WE     <= 1'b0;
            stateReg <= IDLE;
          end else begin
            waitCntReg <= waitCntReg + WAIT_W'(1);
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event on the same edge beats ERR_CLR
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ERR <= 1'b0;
      OVF <= 1'b0;
    end else begin
      if (timeoutPop)   ERR <= 1'b1;
      else if (ERR_CLR) ERR <= 1'b0;
      if (dropStore)    OVF <= 1'b1;
      else if (ERR_CLR) OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dr_store_port.sv
// Directed bench for dr_store_port: store, overflow, timeout, wrap-around, reset.
`timescale 1ns/1ps
module tb_dr_store_port;

  logic        CLK = 1'b0;
  logic        CLR_N = 1'b0;
  logic        ST = 1'b0;
  logic [11:0] inAR = '0;
  logic [15:0] inDR = '0;
  logic        ERR_CLR = 1'b0;
  logic        M_ACK = 1'b0;
  logic        BUSY;
  logic        EMPTY;
  logic        M_WE;
  logic [11:0] M_ADDR;
  logic [15:0] M_DATA;
  logic        ERR;
  logic        OVF;

  int checks = 0;
  int errors = 0;

  logic [27:0] wrLog[$];

  dr_store_port dut (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .ST      (ST),
    .inAR    (inAR),
    .inDR    (inDR),
    .ERR_CLR (ERR_CLR),
    .BUSY    (BUSY),
    .EMPTY   (EMPTY),
    .M_WE    (M_WE),
    .M_ADDR  (M_ADDR),
    .M_DATA  (M_DATA),
    .M_ACK   (M_ACK),
    .ERR     (ERR),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  // Record every accepted write (WE and ACK both high at the edge)
  always @(posedge CLK) begin
    if (CLR_N && M_WE && M_ACK) begin
      wrLog.push_back({M_ADDR, M_DATA});
      $display("write addr=%h data=%h", M_ADDR, M_DATA);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    @(negedge CLK);
    CLR_N = 1'b0;
    #1;
    checks++; if (M_WE !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b expected 0", M_WE); end
    checks++; if (M_ADDR !== 12'h0) begin errors++; $display("FAIL reset_addr: got %h expected 000", M_ADDR); end
    checks++; if (M_DATA !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", M_DATA); end
    checks++; if (EMPTY !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b expected 1", EMPTY); end
    checks++; if (BUSY !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (ERR !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b expected 0", ERR); end
    checks++; if (OVF !== 1'b0)     begin errors++; $display("FAIL reset_ovf: got %b expected 0", OVF); end
    @(negedge CLK);
    CLR_N = 1'b1;
    @(negedge CLK);
    $display("test_reset done");
  endtask

  task automatic test_single_store();
    wrLog.delete();
    M_ACK = 1'b1;
    ST = 1'b1; inAR = 12'h123; inDR = 16'hBEEF;
    @(negedge CLK);
    ST = 1'b0;
    checks++; if (M_WE !== 1'b0) begin errors++; $display("FAIL single_we_early: got %b expected 0", M_WE); end
    @(negedge CLK);
    checks++; if (M_WE !== 1'b1) begin errors++; $display("FAIL single_we_rise: got %b expected 1", M_WE); end
    checks++; if (M_ADDR !== 12'h123) begin errors++; $display("FAIL single_addr: got %h expected 123", M_ADDR); end
    checks++; if (M_DATA !== 16'hBEEF) begin errors++; $display("FAIL single_data: got %h expected beef", M_DATA); end
    @(negedge CLK);
    checks++; if (M_WE !== 1'b0) begin errors++; $display("FAIL single_we_fall: got %b expected 0", M_WE); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", EMPTY); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", ERR); end
    repeat (3) @(negedge CLK);
    M_ACK = 1'b0;
    checks++; if (wrLog.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", wrLog.size()); end
    checks++; if (wrLog.size() < 1 || wrLog[0] !== 28'h123BEEF) begin errors++; $display("FAIL single_log: got %h expected 123beef", (wrLog.size() > 0) ? wrLog[0] : 28'h0); end
    $display("test_single_store done");
  endtask

  task automatic test_overflow();
    wrLog.delete();
    M_ACK = 1'b0;
    ST = 1'b1; inAR = 12'h010; inDR = 16'h0001;
    @(negedge CLK);
    inAR = 12'h011; inDR = 16'h0002;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b expected 1", BUSY); end
    inAR = 12'h012; inDR = 16'h0003;
    @(negedge CLK);
    inAR = 12'h013; inDR = 16'h0004;
    @(negedge CLK);
    ST = 1'b0;
    checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", OVF); end
    M_ACK = 1'b1;
    repeat (8) @(negedge CLK);
    M_ACK = 1'b0;
    checks++; if (wrLog.size() != 2) begin errors++; $display("FAIL ovf_count: got %0d expected 2", wrLog.size()); end
    checks++; if (wrLog.size() < 1 || wrLog[0] !== 28'h0100001) begin errors++; $display("FAIL ovf_first: got %h expected 0100001", (wrLog.size() > 0) ? wrLog[0] : 28'h0); end
    checks++; if (wrLog.size() < 2 || wrLog[1] !== 28'h0110002) begin errors++; $display("FAIL ovf_second: got %h expected 0110002", (wrLog.size() > 1) ? wrLog[1] : 28'h0); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", EMPTY); end
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", OVF); end
    $display("test_overflow done");
  endtask

  task automatic test_timeout();
    int n;
    wrLog.delete();
    M_ACK = 1'b0;
    ST = 1'b1; inAR = 12'h200; inDR = 16'h5555;
    @(negedge CLK);
    ST = 1'b0;
    n = 0;
    while (!M_WE && n < 5) begin @(negedge CLK); n++; end
    n = 0;
    while (M_WE && n < 40) begin @(negedge CLK); n++; end
    checks++; if (n != 15) begin errors++; $display("FAIL timeout_len: got %0d cycles expected 15", n); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", ERR); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL timeout_empty: got %b expected 1", EMPTY); end
    checks++; if (wrLog.size() != 0) begin errors++; $display("FAIL timeout_nowrite: got %0d expected 0", wrLog.size()); end
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", ERR); end
    $display("test_timeout done");
  endtask

  task automatic test_ack_on_timeout();
    int n;
    wrLog.delete();
    M_ACK = 1'b0;
    ST = 1'b1; inAR = 12'h300; inDR = 16'hA5A5;
    @(negedge CLK);
    ST = 1'b0;
    n = 0;
    while (!M_WE && n < 5) begin @(negedge CLK); n++; end
    repeat (14) @(negedge CLK);
    checks++; if (M_WE !== 1'b1) begin errors++; $display("FAIL ackto_still_waiting: got %b expected 1", M_WE); end
    M_ACK = 1'b1;
    @(negedge CLK);
    M_ACK = 1'b0;
    checks++; if (M_WE !== 1'b0) begin errors++; $display("FAIL ackto_we: got %b expected 0", M_WE); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL ackto_err: got %b expected 0", ERR); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL ackto_empty: got %b expected 1", EMPTY); end
    checks++; if (wrLog.size() < 1 || wrLog[0] !== 28'h300A5A5) begin errors++; $display("FAIL ackto_log: got %h expected 300a5a5", (wrLog.size() > 0) ? wrLog[0] : 28'h0); end
    $display("test_ack_on_timeout done");
  endtask

  task automatic test_wraparound();
    int pushed;
    logic didPush;
    logic [27:0] exp;
    wrLog.delete();
    M_ACK = 1'b0;
    ST = 1'b1; inAR = 12'h0A0; inDR = 16'hD000;
    pushed = 1;
    didPush = 1'b0;
    @(negedge CLK);
    ST = 1'b0;
    for (int c = 0; c < 60 && wrLog.size() < 10; c++) begin
      if (didPush) begin
        checks++; if (EMPTY !== 1'b0) begin errors++; $display("FAIL wrap_pushpop_empty: got %b expected 0", EMPTY); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL wrap_pushpop_busy: got %b expected 0", BUSY); end
      end
      M_ACK = M_WE;
      didPush = M_WE && (pushed < 10);
      ST = didPush;
      if (didPush) begin
        inAR = 12'h0A0 + 12'(pushed);
        inDR = 16'hD000 + 16'(pushed);
        pushed++;
      end
      @(negedge CLK);
    end
    M_ACK = 1'b0;
    ST = 1'b0;
    checks++; if (wrLog.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d expected 10", wrLog.size()); end
    for (int i = 0; i < 10; i++) begin
      exp = {12'h0A0 + 12'(i), 16'hD000 + 16'(i)};
      checks++; if (wrLog.size() <= i || wrLog[i] !== exp) begin errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, (wrLog.size() > i) ? wrLog[i] : 28'h0, exp); end
    end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b expected 0", OVF); end
    @(negedge CLK);
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", EMPTY); end
    $display("test_wraparound done");
  endtask

  task automatic test_reset_mid_op();
    wrLog.delete();
    M_ACK = 1'b0;
    ST = 1'b1; inAR = 12'h400; inDR = 16'h0101;
    @(negedge CLK);
    inAR = 12'h401; inDR = 16'h0202;
    @(negedge CLK);
    inAR = 12'h402; inDR = 16'h0303;
    @(negedge CLK);
    ST = 1'b0;
    checks++; if (M_WE !== 1'b1) begin errors++; $display("FAIL midrst_pre_we: got %b expected 1", M_WE); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", BUSY); end
    checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL midrst_pre_ovf: got %b expected 1", OVF); end
    #2;
    CLR_N = 1'b0;
    #1;
    checks++; if (M_WE !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", M_WE); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", EMPTY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", BUSY); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", ERR); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", OVF); end
    @(negedge CLK);
    CLR_N = 1'b1;
    M_ACK = 1'b1;
    repeat (20) @(negedge CLK);
    M_ACK = 1'b0;
    checks++; if (wrLog.size() != 0) begin errors++; $display("FAIL midrst_nowrite: got %0d expected 0", wrLog.size()); end
    checks++; if (M_WE !== 1'b0) begin errors++; $display("FAIL midrst_we_after: got %b expected 0", M_WE); end
    $display("test_reset_mid_op done");
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_overflow();
    test_timeout();
    test_ack_on_timeout();
    test_wraparound();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
